// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and the matching receiver.
// Contents:
//   - parity-mode codes (PAR_NONE / PAR_EVEN / PAR_ODD; 2'b11 behaves as none)
//   - transmitter state encoding
//   - legal ranges for DATA_W and OVERSAMPLE
//   - helpers for the parity-enable decision and parity-bit generation
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int unsigned DATA_W_MIN     = 5;
    localparam int unsigned DATA_W_MAX     = 9;
    localparam int unsigned OVERSAMPLE_MIN = 2;
    localparam int unsigned OVERSAMPLE_MAX = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Data is zero-extended to the widest legal word; the extra zeros do not
    // change the XOR.
    function automatic logic parity_bit(input logic [DATA_W_MAX-1:0] d,
                                        input logic [1:0]            mode);
        return (mode == PAR_ODD) ? ~(^d) : (^d);
    endfunction

endpackage

// File: rtl/uart_tick_edge.sv
// Rising-edge detector for the shared oversample clock.
// Ports:
//   clk     - system clock
//   rst     - synchronous, active-high reset
//   clk_16x - oversample clock, treated as a plain level
//   tick    - high for one clk cycle per clk_16x rising edge
module uart_tick_edge (
    input  logic clk,
    input  logic rst,
    input  logic clk_16x,
    output logic tick
);

    logic clk16_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk16_d <= 1'b0;
        end else begin
            clk16_d <= clk_16x;
        end
    end

    assign tick = clk_16x & ~clk16_d;

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_W data bits, LSB first, optional
// even/odd parity, one or two stop bits, valid/ready input handshake.
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   clk_16x      - oversample clock; OVERSAMPLE rising edges per bit period
//   parity_mode  - 00 none, 01 even, 10 odd, 11 none (latched at accept)
//   stop2        - 1 selects two stop bits (latched at accept)
//   tx_valid     - upstream word valid
//   tx_data      - word to send
//   tx_ready     - high only in IDLE; accept = tx_valid & tx_ready
//   tx           - serial line, idle high, registered
//   tx_busy      - high in every state except IDLE
//   tx_done      - single-cycle pulse on the final tick of the last stop bit
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_16x,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int unsigned BIT_W = $clog2(DATA_W);
    localparam logic [3:0]       TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

    tx_state_e         state, state_n;
    logic [3:0]        tick_cnt, tick_cnt_n;
    logic [BIT_W-1:0]  bit_idx, bit_idx_n;
    logic [DATA_W-1:0] data_q, data_n;
    logic [1:0]        par_q, par_n;
    logic              stop2_q, stop2_n;
    logic              tx_q, tx_n;
    logic              tick;
    logic              boundary;
    logic              done;

    uart_tick_edge u_tick (
        .clk     (clk),
        .rst     (rst),
        .clk_16x (clk_16x),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            data_q   <= '0;
            par_q    <= PAR_NONE;
            stop2_q  <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_cnt_n;
            bit_idx  <= bit_idx_n;
            data_q   <= data_n;
            par_q    <= par_n;
            stop2_q  <= stop2_n;
            tx_q     <= tx_n;
        end
    end

    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_idx_n  = bit_idx;
        data_n     = data_q;
        par_n      = par_q;
        stop2_n    = stop2_q;
        done       = 1'b0;
        boundary   = tick && (tick_cnt == TICK_LAST);

        // Bit-period timing is shared by every non-IDLE state.
        if (state != ST_IDLE && tick) begin
            tick_cnt_n = boundary ? 4'd0 : tick_cnt + 4'd1;
        end

        case (state)
            ST_IDLE: begin
                tick_cnt_n = '0;
                bit_idx_n  = '0;
                if (tx_valid) begin
                    data_n  = tx_data;
                    par_n   = parity_mode;
                    stop2_n = stop2;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (boundary) begin
                    state_n   = ST_DATA;
                    bit_idx_n = '0;
                end
            end
            ST_DATA: begin
                if (boundary) begin
                    if (bit_idx == BIT_LAST) begin
                        bit_idx_n = '0;
                        state_n   = parity_enabled(par_q) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (boundary) begin
                    state_n   = ST_STOP;
                    bit_idx_n = '0;
                end
            end
            ST_STOP: begin
                // bit_idx doubles as the stop-bit counter.
                if (boundary) begin
                    if (stop2_q && bit_idx == '0) begin
                        bit_idx_n = {{(BIT_W-1){1'b0}}, 1'b1};
                    end else begin
                        bit_idx_n = '0;
                        state_n   = ST_IDLE;
                        done      = 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // tx is registered from the next state so the line changes in the
        // same cycle the state register does.
        case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = data_n[bit_idx_n];
            ST_PARITY: tx_n = parity_bit(DATA_W_MAX'(data_n), par_n);
            default:   tx_n = 1'b1;
        endcase
    end

    assign tx       = tx_q;
    assign tx_ready = (state == ST_IDLE);
    assign tx_busy  = (state != ST_IDLE);
    assign tx_done  = done;

endmodule
